word_saboteur: RTL and testbench
================================

WORD_SABOTEUR -- requirements
Module: word_saboteur

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning width of the protected data word.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the delay and duration counters.
REQ-003 SHALL have i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have i_rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have i_data  input  WIDTH  fault-free word.
REQ-006 SHALL have i_mask  input  WIDTH  bits to sabotage; 1 = targeted.
REQ-007 SHALL have i_mode  input  2  00 stuck-at-0, 01 stuck-at-1, 10 bit-flip, 11 intermittent flip.
REQ-008 SHALL have i_delay  input  CNT_W  cycles from arm to fault start.
REQ-009 SHALL have i_duration  input  CNT_W  fault length in cycles; 0 = permanent until abort.
REQ-010 SHALL have i_arm  input  1  single-cycle injection request.
REQ-011 SHALL have i_abort  input  1  cancel the current injection.
REQ-012 SHALL have o_data  output  WIDTH  possibly faulted word.
REQ-013 SHALL have o_active  output  1  fault currently applied.
REQ-014 SHALL have o_busy  output  1  state is DELAY or ACTIVE.
REQ-015 SHALL have o_done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement FSM states IDLE, DELAY, ACTIVE, DONE.
REQ-017 SHALL accept i_arm only in IDLE or DONE; i_arm in DELAY or ACTIVE is ignored.
REQ-018 SHALL latch i_mask, i_mode, i_delay and i_duration on acceptance; later input changes have no effect until the next accept.
REQ-019 SHALL go from accept at edge k to DELAY at k+1 if delay>0, staying exactly delay cycles, otherwise directly to ACTIVE at k+1.
REQ-020 SHALL hold ACTIVE for exactly duration cycles, then DONE for one cycle, then IDLE; DONE with a fresh i_arm goes to DELAY/ACTIVE instead.
REQ-021 SHALL hold ACTIVE indefinitely when duration==0, leaving only via abort or reset.
REQ-022 SHALL, on i_abort in DELAY or ACTIVE, enter IDLE at the next edge with no o_done; abort wins over simultaneous arm.
REQ-023 SHALL compute o_data combinationally: in ACTIVE, each masked bit is forced 0 (mode 00), forced 1 (mode 01), or inverted (mode 10); unmasked bits pass through.
REQ-024 SHALL, in mode 11, invert masked bits on the 1st, 3rd, 5th... ACTIVE cycles and pass i_data on even ACTIVE cycles.
REQ-025 SHALL drive o_data = i_data in IDLE, DELAY and DONE (zero-latency bypass).
REQ-026 SHALL assert o_active equal to (state==ACTIVE), independent of mode phase.
REQ-027 SHALL decrement counters without wrap; no counter underflows for any input values.

Reset
REQ-028 SHALL, on i_rst, enter IDLE, clear counters, latched config and phase; o_active=0, o_busy=0, o_done=0, o_data=i_data.
REQ-029 SHALL, on i_rst asserted during DELAY or ACTIVE, remove the fault at the next edge, and i_rst shall override i_arm.

Configuration
REQ-030 SHALL, with SABOTEUR_INJECT_CNT_EN defined, add output o_inject_cnt (16 bits) that increments on every DONE entry, saturates at 0xFFFF, clears on i_rst, and is not incremented by aborts.
REQ-031 SHALL, without SABOTEUR_INJECT_CNT_EN, omit the port and counter entirely, with all other behaviour unchanged.

Structure
REQ-032 SHALL place the mode encoding and FSM state encoding in shared package saboteur_pkg.
REQ-033 SHALL instantiate sub-module sab_bit_cell once per bit (generate), combinational, taking data bit, mask bit, mode, active and phase.

Verification
REQ-034 SHALL cover: WIDTH=8, mask 0x0F, mode 00, delay 0, duration 3, data 0xFF -> o_data 0xF0 for 3 cycles from arm+1, o_done pulse, then 0xFF.
REQ-035 SHALL cover: mode 10, mask 0x81, delay 5, duration 2, data 0x00 -> 0x00 for 5 cycles, then 0x81 for 2 cycles, then o_done.
REQ-036 SHALL cover: mode 11, mask 0x01, duration 4, data 0x00 -> o_data sequence 01,00,01,00 with o_active high for all 4 cycles.
REQ-037 SHALL cover: duration 0, mode 01, mask 0xFF -> 0xFF held 100 cycles; abort -> i_data next cycle, no o_done.
REQ-038 SHALL cover: i_arm during ACTIVE ignored; i_arm plus i_abort in DELAY -> IDLE; i_rst mid-ACTIVE -> outputs at reset values next cycle.
REQ-039 SHALL cover, with SABOTEUR_INJECT_CNT_EN: 3 completed plus 1 aborted injections -> o_inject_cnt=3.

Source files
------------

// File: rtl/saboteur_pkg.sv
// Shared encodings for the word saboteur: fault modes and controller states.
// Optional build macro used by word_saboteur: SABOTEUR_INJECT_CNT_EN.
package saboteur_pkg;

    typedef enum logic [1:0] {
        MODE_STUCK0   = 2'b00,
        MODE_STUCK1   = 2'b01,
        MODE_FLIP     = 2'b10,
        MODE_INTERMIT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    localparam int INJECT_CNT_W = 16;

endpackage

// File: rtl/sab_bit_cell.sv
// Combinational single-bit fault applier: forces, inverts or passes one data bit.
module sab_bit_cell
    import saboteur_pkg::*;
(
    input  logic  i_data,
    input  logic  i_mask,
    input  mode_t i_mode,
    input  logic  i_active,
    input  logic  i_phase,
    output logic  o_data
);

    always_comb begin
        o_data = i_data;
        if (i_active && i_mask) begin
            case (i_mode)
                MODE_STUCK0:   o_data = 1'b0;
                MODE_STUCK1:   o_data = 1'b1;
                MODE_FLIP:     o_data = ~i_data;
                // Phase is high on odd ACTIVE cycles (first, third, ...).
                MODE_INTERMIT: o_data = i_phase ? ~i_data : i_data;
                default:       o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/word_saboteur.sv
// Fault injector for a data word: armed request, programmable delay and duration.
// Define SABOTEUR_INJECT_CNT_EN to add the o_inject_cnt completed-injection counter.
module word_saboteur
    import saboteur_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_mask,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [CNT_W-1:0] i_duration,
    input  logic             i_arm,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_data,
    output logic             o_active,
    output logic             o_busy,
`ifdef SABOTEUR_INJECT_CNT_EN
    output logic [INJECT_CNT_W-1:0] o_inject_cnt,
`endif
    output logic             o_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_mask,  w_mask_next;
    mode_t            r_mode,  w_mode_next;
    logic [CNT_W-1:0] r_dur,   w_dur_next;
    logic [CNT_W-1:0] r_cnt,   w_cnt_next;
    logic             r_phase, w_phase_next;
    logic             w_accept;
    logic             w_active;

    // Abort has priority over arm, so a combined request never starts an injection.
    assign w_accept = i_arm && !i_abort && (r_state == ST_IDLE || r_state == ST_DONE);

    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_mode_next  = r_mode;
        w_dur_next   = r_dur;
        w_cnt_next   = r_cnt;
        w_phase_next = r_phase;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_phase_next = 1'b0;
                if (w_accept) begin
                    w_mask_next = i_mask;
                    w_mode_next = mode_t'(i_mode);
                    w_dur_next  = i_duration;
                    if (i_delay != '0) begin
                        w_state_next = ST_DELAY;
                        w_cnt_next   = i_delay;
                    end else begin
                        w_state_next = ST_ACTIVE;
                        w_cnt_next   = i_duration;
                        w_phase_next = 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt <= CNT_ONE) begin
                    w_state_next = ST_ACTIVE;
                    w_cnt_next   = r_dur;
                    w_phase_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            ST_ACTIVE: begin
                w_phase_next = ~r_phase;
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_phase_next = 1'b0;
                end else if (r_dur != '0) begin
                    // Zero duration means permanent: the counter is left untouched.
                    if (r_cnt <= CNT_ONE) begin
                        w_state_next = ST_DONE;
                        w_cnt_next   = '0;
                        w_phase_next = 1'b0;
                    end else begin
                        w_cnt_next = r_cnt - CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_phase_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_mode  <= MODE_STUCK0;
            r_dur   <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
            r_mode  <= w_mode_next;
            r_dur   <= w_dur_next;
            r_cnt   <= w_cnt_next;
            r_phase <= w_phase_next;
        end
    end

`ifdef SABOTEUR_INJECT_CNT_EN
    logic [INJECT_CNT_W-1:0] r_inject_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inject_cnt <= '0;
        end else if (r_state == ST_ACTIVE && w_state_next == ST_DONE
                     && r_inject_cnt != {INJECT_CNT_W{1'b1}}) begin
            r_inject_cnt <= r_inject_cnt + 1'b1;
        end
    end

    assign o_inject_cnt = r_inject_cnt;
`endif

    assign w_active = (r_state == ST_ACTIVE);
    assign o_active = w_active;
    assign o_busy   = (r_state == ST_DELAY) || (r_state == ST_ACTIVE);
    assign o_done   = (r_state == ST_DONE);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        sab_bit_cell u_cell (
            .i_data   (i_data[gi]),
            .i_mask   (r_mask[gi]),
            .i_mode   (r_mode),
            .i_active (w_active),
            .i_phase  (r_phase),
            .o_data   (o_data[gi])
        );
    end

endmodule

// File: tb/tb_word_saboteur.sv
// Directed bench for word_saboteur: cycle table plus hand sequences for long/corner cases.
module tb_word_saboteur;

    logic        clk = 1'b0;
    logic        rst, arm, abort;
    logic [1:0]  mode;
    logic [7:0]  data, mask;
    logic [15:0] delay, dur;
    logic [7:0]  o_data;
    logic        o_active, o_busy, o_done;
`ifdef SABOTEUR_INJECT_CNT_EN
    logic [15:0] o_inject_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    word_saboteur #(.WIDTH(8), .CNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (data),
        .i_mask       (mask),
        .i_mode       (mode),
        .i_delay      (delay),
        .i_duration   (dur),
        .i_arm        (arm),
        .i_abort      (abort),
        .o_data       (o_data),
        .o_active     (o_active),
        .o_busy       (o_busy),
`ifdef SABOTEUR_INJECT_CNT_EN
        .o_inject_cnt (o_inject_cnt),
`endif
        .o_done       (o_done)
    );

    typedef struct {
        logic        rst, arm, abort;
        logic [1:0]  mode;
        logic [7:0]  data, mask;
        logic [15:0] delay, dur;
        logic [7:0]  e_data;
        logic        e_active, e_busy, e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic a, input logic ab, input logic [1:0] m,
                       input logic [7:0] d, input logic [7:0] mk, input logic [15:0] dl,
                       input logic [15:0] du, input logic [7:0] ed, input logic ea,
                       input logic eb, input logic edn);
        vec_t v;
        v.rst = r; v.arm = a; v.abort = ab; v.mode = m; v.data = d; v.mask = mk;
        v.delay = dl; v.dur = du; v.e_data = ed; v.e_active = ea; v.e_busy = eb; v.e_done = edn;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Apply inputs just after the falling edge; outputs are sampled 1ns later.
    task automatic step(input logic r, input logic a, input logic ab, input logic [1:0] m,
                        input logic [7:0] d, input logic [7:0] mk, input logic [15:0] dl,
                        input logic [15:0] du);
        @(negedge clk);
        rst = r; arm = a; abort = ab; mode = m; data = d; mask = mk; delay = dl; dur = du;
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] ed, input logic ea,
                             input logic eb, input logic edn);
        check({tag, " data"},   16'(o_data),   16'(ed));
        check({tag, " active"}, 16'(o_active), 16'(ea));
        check({tag, " busy"},   16'(o_busy),   16'(eb));
        check({tag, " done"},   16'(o_done),   16'(edn));
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; mode = 2'd0;
        data = 8'h00; mask = 8'h00; delay = 16'd0; dur = 16'd0;

        // stuck-at-0 on low nibble, no delay, three cycles; config inputs change after arm
        add(0,0,0,0,8'hFF,8'h00,0,0, 8'hFF,0,0,0);
        add(0,1,0,0,8'hFF,8'h0F,0,3, 8'hFF,0,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,1,8'hFF,8'hFF,7,7, 8'hF0,1,1,0);
        add(0,0,0,0,8'hFF,8'h00,0,0, 8'hFF,0,0,1);
        add(0,0,0,0,8'hFF,8'h00,0,0, 8'hFF,0,0,0);
        // bit-flip after a five-cycle delay
        add(0,1,0,2,8'h00,8'h81,5,2, 8'h00,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0,8'h00,8'h00,0,0, 8'h00,0,1,0);
        for (int i = 0; i < 2; i++) add(0,0,0,0,8'h00,8'h00,0,0, 8'h81,1,1,0);
        // re-arm in DONE: intermittent flip, four cycles
        add(0,1,0,3,8'h00,8'h01,0,4, 8'h00,0,0,1);
        add(0,0,0,0,8'h00,8'h00,0,0, 8'h01,1,1,0);
        add(0,0,0,0,8'h00,8'h00,0,0, 8'h00,1,1,0);
        add(0,0,0,0,8'h00,8'h00,0,0, 8'h01,1,1,0);
        add(0,0,0,0,8'h00,8'h00,0,0, 8'h00,1,1,0);
        add(0,0,0,0,8'h00,8'h00,0,0, 8'h00,0,0,1);
        add(0,0,0,0,8'h00,8'h00,0,0, 8'h00,0,0,0);
        // arm while ACTIVE is ignored
        add(0,1,0,0,8'hA5,8'hFF,0,2, 8'hA5,0,0,0);
        add(0,1,0,1,8'hA5,8'h00,0,9, 8'h00,1,1,0);
        add(0,0,0,0,8'hA5,8'h00,0,0, 8'h00,1,1,0);
        add(0,0,0,0,8'hA5,8'h00,0,0, 8'hA5,0,0,1);
        add(0,0,0,0,8'hA5,8'h00,0,0, 8'hA5,0,0,0);
        // arm plus abort in DELAY returns to IDLE without done
        add(0,1,0,2,8'h3C,8'hFF,3,2, 8'h3C,0,0,0);
        add(0,1,1,0,8'h3C,8'hFF,0,1, 8'h3C,0,1,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0,8'h3C,8'h00,0,0, 8'h3C,0,0,0);
        // reset mid-ACTIVE, then reset overriding arm in IDLE
        add(0,1,0,2,8'h55,8'hF0,0,0, 8'h55,0,0,0);
        add(0,0,0,0,8'h55,8'h00,0,0, 8'hA5,1,1,0);
        add(1,1,0,0,8'h55,8'hFF,0,5, 8'hA5,1,1,0);
        add(0,0,0,0,8'h55,8'h00,0,0, 8'h55,0,0,0);
        add(1,1,0,0,8'h55,8'hFF,0,5, 8'h55,0,0,0);
        add(0,0,0,0,8'h55,8'h00,0,0, 8'h55,0,0,0);
        add(0,0,0,0,8'h55,8'h00,0,0, 8'h55,0,0,0);

        step(1,0,0,0,8'hFF,8'h00,0,0);
        step(1,0,0,0,8'hFF,8'h00,0,0);
        step(0,0,0,0,8'h6B,8'h00,0,0);
        check_all("reset", 8'h6B, 0, 0, 0);
`ifdef SABOTEUR_INJECT_CNT_EN
        check("reset inject_cnt", o_inject_cnt, 16'd0);
`endif

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].arm, vecs[i].abort, vecs[i].mode, vecs[i].data,
                 vecs[i].mask, vecs[i].delay, vecs[i].dur);
            check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_active,
                      vecs[i].e_busy, vecs[i].e_done);
        end

        // permanent stuck-at-1 held for 100 cycles, then aborted
        step(0,1,0,1,8'h00,8'hFF,0,0);
        check_all("perm arm", 8'h00, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            step(0,0,0,0,8'(i),8'h00,0,0);
            check($sformatf("perm c%0d data", i), 16'(o_data), 16'h00FF);
            check($sformatf("perm c%0d active", i), 16'(o_active), 16'd1);
        end
        step(0,0,1,0,8'h12,8'h00,0,0);
        check_all("perm abort", 8'hFF, 1, 1, 0);
        step(0,0,0,0,8'h12,8'h00,0,0);
        check_all("perm after1", 8'h12, 0, 0, 0);
        step(0,0,0,0,8'h34,8'h00,0,0);
        check_all("perm after2", 8'h34, 0, 0, 0);

`ifdef SABOTEUR_INJECT_CNT_EN
        // three completed injections and one aborted one
        step(1,0,0,0,8'h00,8'h00,0,0);
        for (int k = 0; k < 3; k++) begin
            step(0,1,0,2,8'h00,8'h01,0,1);
            step(0,0,0,0,8'h00,8'h00,0,0);
            step(0,0,0,0,8'h00,8'h00,0,0);
        end
        step(0,1,0,2,8'h00,8'h01,2,1);
        step(0,0,1,0,8'h00,8'h00,0,0);
        step(0,0,0,0,8'h00,8'h00,0,0);
        step(0,0,0,0,8'h00,8'h00,0,0);
        check("inject_cnt", o_inject_cnt, 16'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
